// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU slice.
//
// Contents:
//   OP_*     3-bit opcode encodings driven on the ALU select input
//   state_t  control FSM states used by alu_seq
// ---------------------------------------------------------------------------
package alu_pkg;

    // Opcode encodings, matching the decoder's select field.
    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    // IDLE: waiting for work.
    // EXEC: iterating a multi-cycle op.
    // FIN:  results just written, done pulse is high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// ---------------------------------------------------------------------------
// alu_iter_unit
// Iterative datapath for the multi-cycle ALU operations. It holds the
// shift-add multiplier registers and the one-bit-per-step shifter. The
// control FSM in alu_seq loads it once per operation and then steps it once
// per clock. The "next" outputs show the value the registers take on the
// coming step, so the FSM can capture the final result on the last step edge.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        capture operands (one cycle, on accept)
//   step        advance the multiplier and shifter by one step
//   op          opcode at load time; only SRA vs. SLL matters here
//   data1       multiplicand / shift source
//   data2       multiplier
//   mul_hi_nxt  product high half after the current step
//   mul_lo_nxt  product low half after the current step
//   sh_val_nxt  shift register value after the current step
//   sh_out_nxt  bit shifted out by the current step
// ---------------------------------------------------------------------------
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] mul_hi_nxt,
    output logic [WIDTH-1:0] mul_lo_nxt,
    output logic [WIDTH-1:0] sh_val_nxt,
    output logic             sh_out_nxt
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] sh_val;
    logic             sra_mode;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   mul_sum;

    // Radix-2 shift-add multiply. {acc_hi, acc_lo} is the 2*WIDTH product
    // register. acc_lo starts as the multiplier, and its LSB decides whether
    // the multiplicand is added into the high half. The (WIDTH+1)-bit sum is
    // then shifted right by one. The sum's carry becomes the new top bit, and
    // the sum's LSB moves into the low half. After WIDTH steps the multiplier
    // has been fully shifted out and the register holds the product.
    always_comb begin
        addend     = acc_lo[0] ? {1'b0, mcand} : '0;
        mul_sum    = {1'b0, acc_hi} + addend;
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end

    // One-bit shifter. SRA copies the sign bit in from the left. SLL fills
    // with zero from the right. The bit that falls off the end is reported
    // so the last one can become the carry flag.
    always_comb begin
        if (sra_mode) begin
            sh_val_nxt = {sh_val[WIDTH-1], sh_val[WIDTH-1:1]};
            sh_out_nxt = sh_val[0];
        end else begin
            sh_val_nxt = {sh_val[WIDTH-2:0], 1'b0};
            sh_out_nxt = sh_val[WIDTH-1];
        end
    end

    // Operand capture on load, then one update per step. The multiplier and
    // the shifter both advance on every step. Only the datapath matching the
    // latched opcode is read back by the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            sh_val   <= '0;
            sra_mode <= 1'b0;
        end else if (load) begin
            mcand    <= data1;
            acc_hi   <= '0;
            acc_lo   <= data2;
            sh_val   <= data1;
            sra_mode <= (op == OP_SRA);
        end else if (step) begin
            acc_hi   <= mul_hi_nxt;
            acc_lo   <= mul_lo_nxt;
            sh_val   <= sh_val_nxt;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered, parametrised ALU that sits between decode and writeback.
// It takes one operation per start handshake. FORWARD, ADD, AND, OR and SUB
// finish on the accepting edge. MUL, SLL and SRA iterate one step per clock
// in alu_iter_unit. On completion the result and flags are registered and
// done pulses for one cycle. The outputs then hold until the next completion.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (aborts any operation)
//   start      request; sampled only when busy is low
//   select     opcode (see alu_pkg)
//   data1      operand A / shift source
//   data2      operand B / unsigned shift amount
//   busy       high while a multi-cycle op is iterating
//   done       one-cycle pulse; results valid from this cycle
//   result     result (low half of the product for MUL)
//   result_hi  high half of the MUL product; 0 for other ops
//   zero       result == 0
//   carry      carry / borrow / last shifted-out bit / MUL high half nonzero
//   overflow   signed overflow for ADD/SUB, else 0
//   negative   result MSB
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    state_t           state;
    state_t           state_nxt;
    logic [SHW-1:0]   count;
    logic [SHW-1:0]   steps;
    logic [2:0]       op_q;
    logic             accept;
    logic             step;
    logic             fin_single;
    logic             fin_iter;
    logic             wr_en;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH-1:0] wr_res;
    logic [WIDTH-1:0] wr_hi;
    logic             wr_c;
    logic             wr_v;

    logic [WIDTH-1:0] mul_hi_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;
    logic [WIDTH-1:0] sh_val_nxt;
    logic             sh_out_nxt;

    // Number of iteration steps for the opcode on the inputs. MUL always
    // takes WIDTH steps. Shift amounts are clamped at WIDTH, because further
    // steps could not change an all-zero or all-sign result. Every other
    // opcode takes zero steps and completes on the accepting edge.
    always_comb begin
        steps = '0;
        case (select)
            OP_MUL: steps = SHW'(WIDTH);
            OP_SLL,
            OP_SRA: begin
                if (data2 >= WIDTH'(WIDTH)) begin
                    steps = SHW'(WIDTH);
                end else begin
                    steps = data2[SHW-1:0];
                end
            end
            default: steps = '0;
        endcase
    end

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode. A request is accepted in IDLE and also
    // in FIN, so a new op can be issued in the same cycle the previous done
    // pulse is visible. While EXEC is active, start is ignored rather than
    // queued. The last step is the one where the counter still reads 1.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        step       = 1'b0;
        fin_single = 1'b0;
        fin_iter   = 1'b0;
        case (state)
            IDLE,
            FIN: begin
                if (start) begin
                    accept = 1'b1;
                    if (steps == '0) begin
                        fin_single = 1'b1;
                        state_nxt  = FIN;
                    end else begin
                        state_nxt  = EXEC;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            EXEC: begin
                step = 1'b1;
                if (count == SHW'(1)) begin
                    fin_iter  = 1'b1;
                    state_nxt = FIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == EXEC);
    assign wr_en = fin_single | fin_iter;

    // Step counter and latched opcode. The counter is loaded with the step
    // count on accept and counts down once per EXEC edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            op_q  <= OP_FWD;
        end else if (accept) begin
            count <= steps;
            op_q  <= select;
        end else if (step) begin
            count <= count - SHW'(1);
        end
    end

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .step       (step),
        .op         (select),
        .data1      (data1),
        .data2      (data2),
        .mul_hi_nxt (mul_hi_nxt),
        .mul_lo_nxt (mul_lo_nxt),
        .sh_val_nxt (sh_val_nxt),
        .sh_out_nxt (sh_out_nxt)
    );

    // Single-cycle arithmetic. The extra top bit gives the carry out for ADD
    // and the borrow for SUB, since a wrapped unsigned subtraction sets it.
    assign add_sum  = {1'b0, data1} + {1'b0, data2};
    assign sub_diff = {1'b0, data1} - {1'b0, data2};

    // Select the values written on completion. An iterative finish takes the
    // post-step values from the iteration unit, so the final step is
    // included. A single-cycle finish decodes the live inputs, because they
    // are accepted on this very edge. Zero-step shifts return data1
    // unchanged with no carry.
    always_comb begin
        wr_res = '0;
        wr_hi  = '0;
        wr_c   = 1'b0;
        wr_v   = 1'b0;
        if (fin_iter) begin
            case (op_q)
                OP_MUL: begin
                    wr_res = mul_lo_nxt;
                    wr_hi  = mul_hi_nxt;
                    wr_c   = |mul_hi_nxt;
                end
                default: begin
                    wr_res = sh_val_nxt;
                    wr_c   = sh_out_nxt;
                end
            endcase
        end else begin
            case (select)
                OP_FWD: wr_res = data2;
                OP_ADD: begin
                    wr_res = add_sum[WIDTH-1:0];
                    wr_c   = add_sum[WIDTH];
                    wr_v   = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                             (add_sum[WIDTH-1] != data1[WIDTH-1]);
                end
                OP_AND: wr_res = data1 & data2;
                OP_OR:  wr_res = data1 | data2;
                OP_SUB: begin
                    wr_res = sub_diff[WIDTH-1:0];
                    wr_c   = sub_diff[WIDTH];
                    wr_v   = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                             (sub_diff[WIDTH-1] != data1[WIDTH-1]);
                end
                default: wr_res = data1;
            endcase
        end
    end

    // Output registers. They change only on a completion edge, so they hold
    // through EXEC. done is high exactly on the cycle after a completion
    // edge. A reset clears them immediately, which also suppresses the done
    // pulse of an aborted operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
        end else begin
            done <= wr_en;
            if (wr_en) begin
                result    <= wr_res;
                result_hi <= wr_hi;
                zero      <= (wr_res == '0);
                carry     <= wr_c;
                overflow  <= wr_v;
                negative  <= wr_res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed self-checking bench for alu_seq at WIDTH=8.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] select;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       zero;
    logic       carry;
    logic       overflow;
    logic       negative;

    int pass_cnt;
    int total_cnt;

    localparam logic [2:0] FWD = 3'b000;
    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] SUB = 3'b100;
    localparam logic [2:0] MUL = 3'b101;
    localparam logic [2:0] SLL = 3'b110;
    localparam logic [2:0] SRA = 3'b111;

    alu_seq #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .select    (select),
        .data1     (data1),
        .data2     (data2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative)
    );

    // Free-running 100 MHz style clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, away from the edge itself.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and count cycles until done. Latency 1 means done is
    // high right after the accepting edge. The operand inputs are scrambled
    // after acceptance to show they no longer matter.
    task automatic run_op(input logic [2:0] sel, input logic [7:0] a,
                          input logic [7:0] b, output int lat);
        start  = 1'b1;
        select = sel;
        data1  = a;
        data2  = b;
        tick();
        start  = 1'b0;
        data1  = ~a;
        data2  = ~b;
        select = ~sel;
        lat    = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        select = ADD;
        data1  = 8'h12;
        data2  = 8'h34;
        tick();
        tick();
        total_cnt++;
        if ({busy, done, result, result_hi, zero, carry, overflow, negative} !== 20'h0)
            $display("[TB] FAIL reset_outputs: got %h want 0",
                     {busy, done, result, result_hi, zero, carry, overflow, negative});
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if ({busy, done} !== 2'b00)
            $display("[TB] FAIL reset_idle: got busy/done %b want 00", {busy, done});
        else pass_cnt++;
    endtask

    task automatic test_add();
        int lat;
        run_op(ADD, 8'h7F, 8'h01, lat);
        total_cnt++;
        if (lat !== 1) $display("[TB] FAIL add_latency: got %0d want 1", lat);
        else pass_cnt++;
        total_cnt++;
        if ({result, result_hi} !== 16'h8000)
            $display("[TB] FAIL add_result: got %h want 8000", {result, result_hi});
        else pass_cnt++;
        total_cnt++;
        if ({zero, carry, overflow, negative} !== 4'b0011)
            $display("[TB] FAIL add_flags zcvn: got %b want 0011",
                     {zero, carry, overflow, negative});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0) $display("[TB] FAIL done_pulse_width: got %b want 0", done);
        else pass_cnt++;
        run_op(ADD, 8'hFF, 8'h01, lat);
        total_cnt++;
        if ({result, zero, carry, overflow, negative} !== {8'h00, 4'b1100})
            $display("[TB] FAIL add_carry: got %h want 00/1100",
                     {result, zero, carry, overflow, negative});
        else pass_cnt++;
        run_op(SUB, 8'h80, 8'h01, lat);
        total_cnt++;
        if ({result, zero, carry, overflow, negative} !== {8'h7F, 4'b0010})
            $display("[TB] FAIL sub_overflow: got %h want 7f/0010",
                     {result, zero, carry, overflow, negative});
        else pass_cnt++;
        run_op(AND, 8'hCC, 8'hAA, lat);
        total_cnt++;
        if ({result, zero, carry, overflow, negative} !== {8'h88, 4'b0001})
            $display("[TB] FAIL and_result: got %h want 88/0001",
                     {result, zero, carry, overflow, negative});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        start  = 1'b1;
        select = SUB;
        data1  = 8'h05;
        data2  = 8'h05;
        tick();
        total_cnt++;
        if ({done, result, zero, carry, overflow, negative} !== {1'b1, 8'h00, 4'b1000})
            $display("[TB] FAIL sub_equal: got %h want 1/00/1000",
                     {done, result, zero, carry, overflow, negative});
        else pass_cnt++;
        data1 = 8'h03;
        data2 = 8'h04;
        tick();
        start = 1'b0;
        total_cnt++;
        if ({done, result, zero, carry, overflow, negative} !== {1'b1, 8'hFF, 4'b0101})
            $display("[TB] FAIL sub_back_to_back: got %h want 1/ff/0101",
                     {done, result, zero, carry, overflow, negative});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (done !== 1'b0) $display("[TB] FAIL b2b_done_drop: got %b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_mul();
        int lat;
        int busy_cnt;
        int held_bad;
        int late_done;
        start  = 1'b1;
        select = MUL;
        data1  = 8'd200;
        data2  = 8'd3;
        tick();
        start    = 1'b0;
        data1    = 8'h00;
        data2    = 8'h00;
        lat      = 1;
        busy_cnt = 0;
        held_bad = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (result !== 8'hFF) held_bad++;
            if (lat == 3) begin
                start  = 1'b1;
                select = ADD;
                data1  = 8'h01;
                data2  = 8'h01;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        total_cnt++;
        if (lat !== 9) $display("[TB] FAIL mul_latency: got %0d want 9", lat);
        else pass_cnt++;
        total_cnt++;
        if (busy_cnt !== 8) $display("[TB] FAIL mul_busy_cycles: got %0d want 8", busy_cnt);
        else pass_cnt++;
        total_cnt++;
        if (held_bad !== 0) $display("[TB] FAIL mul_hold_in_exec: got %0d changes want 0", held_bad);
        else pass_cnt++;
        total_cnt++;
        if ({result, result_hi, zero, carry, overflow, negative} !== {16'h5802, 4'b0100})
            $display("[TB] FAIL mul_result: got %h want 5802/0100",
                     {result, result_hi, zero, carry, overflow, negative});
        else pass_cnt++;
        late_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) late_done++;
        end
        total_cnt++;
        if (late_done !== 0 || result !== 8'h58)
            $display("[TB] FAIL mul_start_ignored: got %0d extra cycles result %h want 0 58",
                     late_done, result);
        else pass_cnt++;
    endtask

    task automatic test_shift();
        int lat;
        run_op(SRA, 8'h90, 8'd3, lat);
        total_cnt++;
        if (lat !== 4 || {result, zero, carry, overflow, negative} !== {8'hF2, 4'b0001})
            $display("[TB] FAIL sra_by_3: got lat %0d %h want 4 f2/0001",
                     lat, {result, zero, carry, overflow, negative});
        else pass_cnt++;
        run_op(SLL, 8'h81, 8'd9, lat);
        total_cnt++;
        if (lat !== 9 || {result, zero, carry, overflow, negative} !== {8'h00, 4'b1100})
            $display("[TB] FAIL sll_by_9: got lat %0d %h want 9 00/1100",
                     lat, {result, zero, carry, overflow, negative});
        else pass_cnt++;
        run_op(SLL, 8'h5A, 8'd0, lat);
        total_cnt++;
        if (lat !== 1 || {result, zero, carry, overflow, negative} !== {8'h5A, 4'b0000})
            $display("[TB] FAIL sll_by_0: got lat %0d %h want 1 5a/0000",
                     lat, {result, zero, carry, overflow, negative});
        else pass_cnt++;
        run_op(SLL, 8'h81, 8'd1, lat);
        total_cnt++;
        if (lat !== 2 || {result, zero, carry, overflow, negative} !== {8'h02, 4'b0100})
            $display("[TB] FAIL sll_by_1: got lat %0d %h want 2 02/0100",
                     lat, {result, zero, carry, overflow, negative});
        else pass_cnt++;
        run_op(SRA, 8'h80, 8'd20, lat);
        total_cnt++;
        if (lat !== 9 || {result, result_hi, zero, carry, overflow, negative} !== {16'hFF00, 4'b0101})
            $display("[TB] FAIL sra_by_20: got lat %0d %h want 9 ff00/0101",
                     lat, {result, result_hi, zero, carry, overflow, negative});
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int lat;
        int late_done;
        start  = 1'b1;
        select = MUL;
        data1  = 8'hFF;
        data2  = 8'hFF;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, result, result_hi, zero, carry, overflow, negative} !== 20'h0)
            $display("[TB] FAIL abort_outputs: got %h want 0",
                     {busy, done, result, result_hi, zero, carry, overflow, negative});
        else pass_cnt++;
        tick();
        rst_n     = 1'b1;
        late_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) late_done++;
        end
        total_cnt++;
        if (late_done !== 0) $display("[TB] FAIL abort_no_done: got %0d active cycles want 0", late_done);
        else pass_cnt++;
        run_op(OR, 8'hF0, 8'h0F, lat);
        total_cnt++;
        if (lat !== 1 || {result, zero, carry, overflow, negative} !== {8'hFF, 4'b0001})
            $display("[TB] FAIL or_after_abort: got lat %0d %h want 1 ff/0001",
                     lat, {result, zero, carry, overflow, negative});
        else pass_cnt++;
    endtask

    task automatic test_forward_after_mul();
        int lat;
        run_op(MUL, 8'h10, 8'h20, lat);
        total_cnt++;
        if (lat !== 9 || {result, result_hi, zero, carry, overflow, negative} !== {16'h0002, 4'b1100})
            $display("[TB] FAIL mul_low_zero: got lat %0d %h want 9 0002/1100",
                     lat, {result, result_hi, zero, carry, overflow, negative});
        else pass_cnt++;
        run_op(FWD, 8'hAB, 8'h00, lat);
        total_cnt++;
        if (lat !== 1 || {result, result_hi, zero, carry, overflow, negative} !== {16'h0000, 4'b1000})
            $display("[TB] FAIL fwd_after_mul: got lat %0d %h want 1 0000/1000",
                     lat, {result, result_hi, zero, carry, overflow, negative});
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        $display("[TB] alu_seq directed tests starting");
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_shift();
        test_reset_abort();
        test_forward_after_mul();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
